uart_controller: RTL and testbench

UART_CONTROLLER -- requirements
Module: uart_controller

---
 rtl/uart_controller.sv | 210 +++++++++++++++++++++
 tb/tb_uart_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_controller.sv
// APB-mapped UART: one TX and one RX engine, 8 data bits, LSB first, 1 stop bit.
// Define UART_PARITY_EN to add an even-parity bit (generated on TX, checked on RX).
module uart_controller #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  input  logic        RX,
  output logic        TX,
  output logic        TX_DONE,
  output logic        ERROR,
  output logic        FULL
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          r_tx_st, w_tx_nx, r_rx_st, w_rx_nx;
  logic [CW-1:0]   r_tx_cnt, r_rx_cnt;
  logic [2:0]      r_tx_bit, r_rx_bit;
  logic [7:0]      r_tx_data, r_tx_shift, r_rx_shift, r_rx_data;
  logic            r_tx_done_p, r_rx_meta, r_rx_sync, r_rx_prev;
  logic            r_full, r_perr, r_ferr, r_ovr, r_txdone;
`ifdef UART_PARITY_EN
  logic            r_rx_par;
`endif
  logic            w_wr, w_rd, w_tx_go, w_tx_last, w_rx_last, w_store, w_tx_end, w_stat_wr;
  logic [7:0]      w_addr;
  logic            w_unused;

  assign w_addr    = paddr[7:0];
  assign w_wr      = psel & penable & pwrite;
  assign w_rd      = psel & penable & ~pwrite;
  assign w_tx_go   = w_wr && (w_addr == 8'h00) && (r_tx_st == S_IDLE);
  assign w_stat_wr = w_wr && (w_addr == 8'h08);
  assign w_tx_last = (r_tx_cnt == LAST);
  assign w_rx_last = (r_rx_cnt == LAST);
  assign w_tx_end  = (r_tx_st == S_STOP) && w_tx_last;
  assign w_store   = (r_rx_st == S_STOP) && w_rx_last;
  assign w_unused  = ^{paddr[31:8], pwdata[31:8]};

  // ---------------- TX ----------------
  always_ff @(posedge pclk) begin
    if (presetn) r_tx_st <= S_IDLE;
    else         r_tx_st <= w_tx_nx;
  end

  always_comb begin
    w_tx_nx = r_tx_st;
    TX      = 1'b1;
    case (r_tx_st)
      S_IDLE:   if (w_tx_go) w_tx_nx = S_START;
      S_START:  begin TX = 1'b0; if (w_tx_last) w_tx_nx = S_DATA; end
      S_DATA: begin
        TX = r_tx_shift[0];
        if (w_tx_last && r_tx_bit == 3'd7)
`ifdef UART_PARITY_EN
          w_tx_nx = S_PARITY;
`else
          w_tx_nx = S_STOP;
`endif
      end
      S_PARITY: begin TX = ^r_tx_data; if (w_tx_last) w_tx_nx = S_STOP; end
      S_STOP:   if (w_tx_last) w_tx_nx = S_IDLE;
      default:  w_tx_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (presetn) begin
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_data   <= '0;
      r_tx_shift  <= '0;
      r_tx_done_p <= 1'b0;
    end else begin
      r_tx_done_p <= w_tx_end;
      if (w_tx_go) begin
        r_tx_data  <= pwdata[7:0];
        r_tx_shift <= pwdata[7:0];
        r_tx_cnt   <= '0;
        r_tx_bit   <= '0;
      end else if (r_tx_st != S_IDLE) begin
        r_tx_cnt <= w_tx_last ? '0 : r_tx_cnt + 1'b1;
        if (w_tx_last && r_tx_st == S_DATA) begin
          r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          r_tx_bit   <= r_tx_bit + 1'b1;
        end
      end
    end
  end

  // ---------------- RX ----------------
  // prev lets IDLE react to a falling edge only, never to a line held low.
  always_ff @(posedge pclk) begin
    if (presetn) {r_rx_meta, r_rx_sync, r_rx_prev} <= 3'b111;
    else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge pclk) begin
    if (presetn) r_rx_st <= S_IDLE;
    else         r_rx_st <= w_rx_nx;
  end

  always_comb begin
    w_rx_nx = r_rx_st;
    case (r_rx_st)
      S_IDLE:   if (r_rx_prev && !r_rx_sync) w_rx_nx = S_START;
      S_START:  if (r_rx_cnt == HALF) w_rx_nx = r_rx_sync ? S_IDLE : S_DATA;
      S_DATA:
        if (w_rx_last && r_rx_bit == 3'd7)
`ifdef UART_PARITY_EN
          w_rx_nx = S_PARITY;
`else
          w_rx_nx = S_STOP;
`endif
      S_PARITY: if (w_rx_last) w_rx_nx = S_STOP;
      S_STOP:   if (w_rx_last) w_rx_nx = S_IDLE;
      default:  w_rx_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (presetn) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
`ifdef UART_PARITY_EN
      r_rx_par   <= 1'b0;
`endif
    end else begin
      case (r_rx_st)
        S_IDLE:  begin r_rx_cnt <= '0; r_rx_bit <= '0; end
        S_START: r_rx_cnt <= (r_rx_cnt == HALF) ? '0 : r_rx_cnt + 1'b1;
        default: begin
          r_rx_cnt <= w_rx_last ? '0 : r_rx_cnt + 1'b1;
          if (w_rx_last && r_rx_st == S_DATA) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
          end
`ifdef UART_PARITY_EN
          if (w_rx_last && r_rx_st == S_PARITY) r_rx_par <= r_rx_sync;
`endif
        end
      endcase
    end
  end

  // ---------------- status / holding register ----------------
  // Set conditions are tested first so a new event beats a same-cycle clear.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      r_rx_data <= '0;
      r_full    <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_txdone  <= 1'b0;
    end else begin
      if (w_store) r_rx_data <= r_rx_shift;

      if (w_store)                          r_full <= 1'b1;
      else if (w_rd && w_addr == 8'h04)     r_full <= 1'b0;

      if (w_store && r_full)                r_ovr <= 1'b1;
      else if (w_stat_wr && pwdata[5])      r_ovr <= 1'b0;

      if (w_store && !r_rx_sync)            r_ferr <= 1'b1;
      else if (w_stat_wr && pwdata[4])      r_ferr <= 1'b0;

`ifdef UART_PARITY_EN
      if (w_store && (r_rx_par != ^r_rx_shift)) r_perr <= 1'b1;
      else if (w_stat_wr && pwdata[3])          r_perr <= 1'b0;
`else
      r_perr <= 1'b0;
`endif

      if (w_tx_end)                         r_txdone <= 1'b1;
      else if (w_stat_wr && pwdata[1])      r_txdone <= 1'b0;
    end
  end

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (w_addr)
        8'h00:   prdata = {24'h0, r_tx_data};
        8'h04:   prdata = {24'h0, r_rx_data};
        8'h08:   prdata = {26'h0, r_ovr, r_ferr, r_perr, r_full, r_txdone, r_tx_st != S_IDLE};
        default: prdata = '0;
      endcase
    end
  end

  assign TX_DONE = r_tx_done_p;
  assign ERROR   = r_perr | r_ferr;
  assign FULL    = r_full;
endmodule

// File: tb/tb_uart_controller.sv
// Bench for uart_controller: frame-level reference model, per-cycle compare of
// TX/TX_DONE/FULL/ERROR/prdata, directed register cases plus randomized frames.
module tb_uart_controller;
  localparam int CPB = 20;
`ifdef UART_PARITY_EN
  localparam int NB  = 11;
  localparam bit PEN = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PEN = 1'b0;
`endif

  logic        pclk = 1'b0, presetn = 1'b1;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] prdata;
  logic        RX = 1'b1;
  logic        TX, TX_DONE, ERROR, FULL;

  uart_controller #(.CLKS_PER_BIT(CPB)) dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .RX(RX), .TX(TX),
    .TX_DONE(TX_DONE), .ERROR(ERROR), .FULL(FULL));

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // reference model state
  int         tx_w = -1, clr_cyc = -1;
  logic [7:0] tx_byte = '0, txd_reg = '0, rx_byte = '0;
  bit         prev_done = 0, m_full = 0, m_perr = 0, m_ferr = 0, m_ovr = 0;
  bit         rx_settled = 1, chk_en = 0;
  // posted checks from the stimulus side
  bit          pend = 0, pend_prd = 0;
  string       pend_name = "";
  logic [31:0] pend_act = '0, pend_exp = '0;
  int          n_cmp = 0, n_bad = 0;

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (PEN && i == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic bit m_busy(input int c);
    return tx_w >= 0 && c >= tx_w && c < tx_w + NB*CPB;
  endfunction

  function automatic bit m_txdone(input int c);
    return prev_done || (tx_w >= 0 && c >= tx_w + NB*CPB && clr_cyc <= tx_w + NB*CPB);
  endfunction

  function automatic logic [31:0] m_status(input int c);
    return {26'h0, m_ovr, m_ferr, m_perr, m_full, m_txdone(c), m_busy(c)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge pclk) begin : cmp_p
    int c;
    logic etx;
    if (chk_en) begin
      c   = cyc;
      etx = 1'b1;
      if (m_busy(c)) etx = frame_bit(tx_byte, (c - tx_w) / CPB);
      check("TX", 32'(TX), 32'(etx));
      check("TX_DONE", 32'(TX_DONE), 32'(tx_w >= 0 && c == tx_w + NB*CPB));
      if (rx_settled) begin
        check("FULL", 32'(FULL), 32'(m_full));
        check("ERROR", 32'(ERROR), 32'(m_perr | m_ferr));
      end
      if (!psel) check("prdata_idle", prdata, 32'h0);
      if (pend) check(pend_name, pend_prd ? prdata : pend_act, pend_exp);
    end
  end

  task automatic tick;
    @(posedge pclk); #1;
  endtask

  task automatic do_reset(input int n);
    presetn = 1'b1;
    tick;
    tx_w = -1; clr_cyc = -1; prev_done = 0; txd_reg = '0; rx_byte = '0;
    m_full = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
    chk_en = 1;
    repeat (n - 1) tick;
    presetn = 1'b0;
  endtask

  task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
    pend_name = nm; pend_act = act; pend_exp = exp; pend_prd = 0; pend = 1;
    tick;
    pend = 0;
  endtask

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input int e);
    if (a[7:0] == 8'h00 && !(tx_w >= 0 && e <= tx_w + NB*CPB)) begin
      prev_done = prev_done || (tx_w >= 0 && clr_cyc <= tx_w + NB*CPB);
      tx_w = e; tx_byte = d[7:0]; txd_reg = d[7:0];
    end
    if (a[7:0] == 8'h08) begin
      if (d[1]) begin prev_done = 0; clr_cyc = e; end
      if (d[3]) m_perr = 0;
      if (d[4]) m_ferr = 0;
      if (d[5]) m_ovr  = 0;
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, input int n);
    paddr = a; pwdata = d; psel = 1; pwrite = 1; penable = 0;
    tick;
    penable = 1;
    for (int k = 0; k < n; k++) begin
      tick;
      model_wr(a, d, cyc);
    end
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    paddr = a; psel = 1; pwrite = 0; penable = 0;
    pend_name = nm; pend_exp = exp; pend_prd = 1; pend = 1;
    tick;
    pend = 0; penable = 1;
    tick;
    if (a[7:0] == 8'h04) m_full = 0;
    psel = 0; penable = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit badp);
    logic v;
    rx_settled = 0;
    for (int i = 0; i < NB; i++) begin
      v = frame_bit(b, i);
      if (PEN && i == 9 && badp) v = ~v;
      if (i == NB - 1) v = stop;
      RX = v;
      repeat (CPB) tick;
    end
    m_ovr = m_ovr | m_full;
    m_full = 1; rx_byte = b;
    if (!stop) m_ferr = 1;
    if (PEN && badp) m_perr = 1;
    RX = 1'b1;
    tick; tick;
    rx_settled = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, found, dly, nh;
    logic [7:0] b, tb;
    bit st, bp;

    do_reset(3);
    apb_rd(32'h08, 32'h0, "status_rst");
    apb_rd(32'h04, 32'h0, "rxdata_rst");
    apb_rd(32'h00, 32'h0, "txdata_rst");

    // clean 0x55, then frame error, then overrun
    send_frame(8'h55, 1, 0);
    apb_rd(32'h08, 32'h4,  "status_rx55");
    apb_rd(32'h04, 32'h55, "rxdata_55");
    apb_rd(32'h08, 32'h0,  "status_after_read");
    send_frame(8'h55, 0, 0);
    apb_rd(32'h08, 32'h14, "status_ferr");
    apb_rd(32'h04, 32'h55, "rxdata_ferr");
    apb_wr(32'h08, 32'h10, 1);
    apb_rd(32'h08, 32'h0,  "status_ferr_clr");
    send_frame(8'h55, 1, 0);
    send_frame(8'h33, 1, 0);
    apb_rd(32'h08, 32'h24, "status_ovr");
    apb_rd(32'h04, 32'h33, "rxdata_ovr");
    apb_wr(32'h08, 32'h3A, 1);

    // short low glitch must be rejected
    RX = 1'b0; repeat (4) tick; RX = 1'b1;
    repeat (3*CPB) tick;
    apb_rd(32'h08, 32'h0, "status_glitch");

`ifdef UART_PARITY_EN
    send_frame(8'h0F, 1, 1);
    apb_rd(32'h08, 32'h0C, "status_perr");
    apb_rd(32'h04, 32'h0F, "rxdata_perr");
    apb_wr(32'h08, 32'h08, 1);
`endif

    // TX 0xAA and TX_DONE latency
    apb_wr(32'h00, 32'hAA, 1);
    w0 = cyc; found = -1;
    for (int k = 0; k < NB*CPB + 20 && found < 0; k++) begin
      tick;
      if (TX_DONE) found = cyc - w0;
    end
    post("tx_done_latency", 32'(found), 32'(NB*CPB));
    apb_rd(32'h08, 32'h2, "status_txdone");

    // held write starts one frame; writes while busy ignored
    apb_wr(32'h00, 32'h3C, 3);
    repeat (NB*CPB + 5) tick;
    apb_rd(32'h00, 32'h3C, "txdata_held");
    apb_wr(32'h00, 32'h11, 1);
    repeat (5) tick;
    apb_wr(32'h00, 32'h22, 1);
    apb_rd(32'h00, 32'h11, "txdata_busy_ignored");
    repeat (NB*CPB) tick;
    apb_wr(32'h0C, 32'hFF, 1);
    apb_rd(32'h0C, 32'h0, "unmapped");

    // reset in the middle of a TX frame
    apb_wr(32'h00, 32'h96, 1);
    repeat (3*CPB) tick;
    do_reset(2);
    apb_rd(32'h08, 32'h0, "status_after_reset");

    // randomized RX frames with concurrent TX traffic
    for (int it = 0; it < 12; it++) begin
      b   = 8'($urandom);
      tb  = 8'($urandom);
      st  = ($urandom_range(0, 3) != 0);
      bp  = PEN && ($urandom_range(0, 1) == 1);
      dly = $urandom_range(1, 60);
      nh  = $urandom_range(1, 3);
      fork
        send_frame(b, st, bp);
        begin
          repeat (dly) tick;
          apb_wr(32'h00, {24'h0, tb}, nh);
        end
      join
      if ($urandom_range(0, 1) == 1) apb_rd(32'h04, {24'h0, rx_byte}, "rand_rxdata");
      apb_rd(32'h08, m_status(cyc), "rand_status");
      if ($urandom_range(0, 2) == 0) apb_wr(32'h08, $urandom & 32'h3A, 1);
    end
    repeat (NB*CPB + 5) tick;
    apb_rd(32'h08, m_status(cyc), "final_status");
    apb_rd(32'h00, {24'h0, txd_reg}, "final_txdata");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
